// File: rtl/alu_wide_sequencer_pkg.sv
// Shared ALU definitions and wide-sequencer helpers: opcode/flag encodings,
// sequencer states, supported-op check and per-word opcode mapping.
package alu_wide_sequencer_pkg;

  localparam int ALU_W = 8;
  localparam int ALU_OPER_W = 4;
  localparam int FLAGS_W = 4;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [ALU_OPER_W-1:0] {
    enum_alu_oper_add = 4'd0,
    enum_alu_oper_adc = 4'd1,
    enum_alu_oper_sub = 4'd2,
    enum_alu_oper_sbc = 4'd3,
    enum_alu_oper_cmp = 4'd4,
    enum_alu_oper_and = 4'd5,
    enum_alu_oper_orr = 4'd6,
    enum_alu_oper_xor = 4'd7,
    enum_alu_oper_lsl = 4'd8,
    enum_alu_oper_lsr = 4'd9,
    enum_alu_oper_rol = 4'd10,
    enum_alu_oper_ror = 4'd11
  } alu_oper_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_FIN  = 2'd2
  } seq_state_e;

  // Shifts and rotates move bits across word boundaries, so they cannot be chained.
  function automatic logic oper_supported(input logic [ALU_OPER_W-1:0] oper);
    case (oper)
      enum_alu_oper_add, enum_alu_oper_adc, enum_alu_oper_sub, enum_alu_oper_sbc,
      enum_alu_oper_cmp, enum_alu_oper_and, enum_alu_oper_orr, enum_alu_oper_xor:
        oper_supported = 1'b1;
      default:
        oper_supported = 1'b0;
    endcase
  endfunction

  function automatic logic [ALU_OPER_W-1:0] word_oper(input logic [ALU_OPER_W-1:0] oper,
                                                       input logic first);
    word_oper = oper;
    if (!first) begin
      case (oper)
        enum_alu_oper_add, enum_alu_oper_adc:
          word_oper = enum_alu_oper_adc;
        enum_alu_oper_sub, enum_alu_oper_sbc, enum_alu_oper_cmp:
          word_oper = enum_alu_oper_sbc;
        default:
          word_oper = oper;
      endcase
    end
  endfunction

endpackage

// File: rtl/alu_wide_sequencer_alu.sv
// Single-word ALU. Subtract carry means "no borrow"; logic ops pass carry through.
module alu
  import alu_wide_sequencer_pkg::*;
(
  input  logic [ALU_OPER_W-1:0] oper,
  input  logic [ALU_W-1:0]      a,
  input  logic [ALU_W-1:0]      b,
  input  logic                  carry,
  output logic [ALU_W-1:0]      result,
  output logic                  c,
  output logic                  z
);

  logic [ALU_W:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    c      = carry;
    case (oper)
      enum_alu_oper_add: sum = {1'b0, a} + {1'b0, b};
      enum_alu_oper_adc: sum = {1'b0, a} + {1'b0, b} + {{ALU_W{1'b0}}, carry};
      enum_alu_oper_sub,
      enum_alu_oper_cmp: sum = {1'b0, a} + {1'b0, ~b} + {{ALU_W{1'b0}}, 1'b1};
      enum_alu_oper_sbc: sum = {1'b0, a} + {1'b0, ~b} + {{ALU_W{1'b0}}, carry};
      enum_alu_oper_and: sum = {carry, a & b};
      enum_alu_oper_orr: sum = {carry, a | b};
      enum_alu_oper_xor: sum = {carry, a ^ b};
      enum_alu_oper_lsl: sum = {a, 1'b0};
      enum_alu_oper_lsr: sum = {a[0], 1'b0, a[ALU_W-1:1]};
      enum_alu_oper_rol: sum = {a, carry};
      enum_alu_oper_ror: sum = {a[0], carry, a[ALU_W-1:1]};
      default:           sum = {carry, a};
    endcase
    result = sum[ALU_W-1:0];
    c      = sum[ALU_W];
    z      = (result == '0);
  end

endmodule

// File: rtl/alu_wide_sequencer.sv
// Runs one NUM_WORDS-wide operation through a single word ALU, LS word first,
// chaining carry and accumulating Z, with a start/busy/done handshake.
module alu_wide_sequencer
  import alu_wide_sequencer_pkg::*;
#(
  parameter int NUM_WORDS = 2,
  parameter int WORD_W    = ALU_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [ALU_OPER_W-1:0]       oper,
  input  logic [NUM_WORDS*WORD_W-1:0] a_in,
  input  logic [NUM_WORDS*WORD_W-1:0] b_in,
  input  logic [FLAGS_W-1:0]          proc_flags_in,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [NUM_WORDS*WORD_W-1:0] out,
  output logic [FLAGS_W-1:0]          proc_flags_out
);

  localparam int IDX_W  = $clog2(NUM_WORDS);
  localparam int WIDE_W = NUM_WORDS * WORD_W;

  seq_state_e state, state_next;

  logic [WIDE_W-1:0]     a_lat, b_lat;
  logic [ALU_OPER_W-1:0] oper_lat, alu_oper;
  logic [FLAGS_W-1:0]    flags_lat, flags_fin;
  logic [IDX_W-1:0]      idx;
  logic                  z_acc, c_cur, last_word;
  logic [WORD_W-1:0]     a_word, b_word, alu_result;
  logic                  alu_c, alu_z;

  assign a_word    = a_lat[int'(idx)*WORD_W +: WORD_W];
  assign b_word    = b_lat[int'(idx)*WORD_W +: WORD_W];
  assign alu_oper  = word_oper(oper_lat, idx == '0);
  assign last_word = (idx == IDX_W'(NUM_WORDS - 1));
  assign busy      = (state == SEQ_RUN);
  assign done      = (state == SEQ_FIN);

  alu u_alu (
    .oper   (alu_oper),
    .a      (a_word),
    .b      (b_word),
    .carry  (c_cur),
    .result (alu_result),
    .c      (alu_c),
    .z      (alu_z)
  );

  always_comb begin
    flags_fin         = flags_lat;
    flags_fin[FLAG_C] = alu_c;
    flags_fin[FLAG_Z] = z_acc & alu_z;
  end

  always_comb begin
    state_next = state;
    case (state)
      SEQ_IDLE: if (start) state_next = oper_supported(oper) ? SEQ_RUN : SEQ_FIN;
      SEQ_RUN:  if (last_word) state_next = SEQ_FIN;
      SEQ_FIN:  state_next = SEQ_IDLE;
      default:  state_next = SEQ_IDLE;
    endcase
  end

  // Operand latches carry no reset; they are only read after an accepted start.
  always_ff @(posedge clk) begin
    if (state == SEQ_IDLE && start) begin
      a_lat     <= a_in;
      b_lat     <= b_in;
      oper_lat  <= oper;
      flags_lat <= proc_flags_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= SEQ_IDLE;
      err            <= 1'b0;
      out            <= '0;
      proc_flags_out <= '0;
      idx            <= '0;
      z_acc          <= 1'b1;
      c_cur          <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        SEQ_IDLE: begin
          if (start) begin
            idx   <= '0;
            z_acc <= 1'b1;
            c_cur <= proc_flags_in[FLAG_C];
            err   <= !oper_supported(oper);
            if (!oper_supported(oper)) begin
              out            <= a_in;
              proc_flags_out <= proc_flags_in;
            end
          end
        end
        SEQ_RUN: begin
          // cmp only sets flags; the destination keeps operand A.
          out[int'(idx)*WORD_W +: WORD_W] <= (oper_lat == enum_alu_oper_cmp) ? a_word : alu_result;
          c_cur <= alu_c;
          z_acc <= z_acc & alu_z;
          idx   <= idx + IDX_W'(1);
          if (last_word) proc_flags_out <= flags_fin;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Self-checking bench for alu_wide_sequencer (NUM_WORDS=2, 8-bit words).
module tb_alu_wide_sequencer;
  import alu_wide_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, start;
  logic [3:0]  oper;
  logic [15:0] a_in, b_in, out;
  logic [3:0]  proc_flags_in, proc_flags_out;
  logic        busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_wide_sequencer #(.NUM_WORDS(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .oper           (oper),
    .a_in           (a_in),
    .b_in           (b_in),
    .proc_flags_in  (proc_flags_in),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .out            (out),
    .proc_flags_out (proc_flags_out)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  f;
    logic [15:0] eo;
    logic [3:0]  ef;
    logic        ee;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: whole-operand arithmetic on 16-bit values; flags bit0=C, bit1=Z.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] f, output logic [15:0] r,
                                output logic [3:0] fo, output logic e);
    int   v;
    logic cin;
    cin = f[0];
    fo  = f;
    e   = 1'b0;
    v   = 0;
    case (op)
      enum_alu_oper_add: v = int'(a) + int'(b);
      enum_alu_oper_adc: v = int'(a) + int'(b) + int'(cin);
      enum_alu_oper_sub,
      enum_alu_oper_cmp: v = int'(a) - int'(b);
      enum_alu_oper_sbc: v = int'(a) - int'(b) - (1 - int'(cin));
      enum_alu_oper_and: v = int'(a & b);
      enum_alu_oper_orr: v = int'(a | b);
      enum_alu_oper_xor: v = int'(a ^ b);
      default:           e = 1'b1;
    endcase
    if (e) begin
      r = a;
    end else begin
      r = (op == enum_alu_oper_cmp) ? a : v[15:0];
      fo[1] = (v[15:0] == 16'h0);
      case (op)
        enum_alu_oper_add, enum_alu_oper_adc: fo[0] = (v > 65535);
        enum_alu_oper_sub, enum_alu_oper_cmp,
        enum_alu_oper_sbc:                    fo[0] = (v >= 0);
        default:                              fo[0] = cin;
      endcase
    end
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] f, output logic [15:0] r, output logic [3:0] fo,
                        output logic e, output int lat);
    @(negedge clk);
    oper = op; a_in = a; b_in = b; proc_flags_in = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r  = out;
    fo = proc_flags_out;
    e  = err;
  endtask

  initial begin
    logic [15:0] r, mo;
    logic [3:0]  fo, mf;
    logic        e, me;
    int          lat, dones;

    reset_n = 1'b0; start = 1'b0; oper = '0; a_in = '0; b_in = '0; proc_flags_in = '0;

    vecs[0]  = '{enum_alu_oper_add, 16'h00FF, 16'h0001, 4'b0000, 16'h0100, 4'b0000, 1'b0};
    vecs[1]  = '{enum_alu_oper_add, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011, 1'b0};
    vecs[2]  = '{enum_alu_oper_sub, 16'h0100, 16'h0001, 4'b0000, 16'h00FF, 4'b0001, 1'b0};
    vecs[3]  = '{enum_alu_oper_sbc, 16'h0000, 16'h0000, 4'b0000, 16'hFFFF, 4'b0000, 1'b0};
    vecs[4]  = '{enum_alu_oper_cmp, 16'h1234, 16'h1234, 4'b0000, 16'h1234, 4'b0011, 1'b0};
    vecs[5]  = '{enum_alu_oper_and, 16'hF0F0, 16'h0FF0, 4'b0001, 16'h00F0, 4'b0001, 1'b0};
    vecs[6]  = '{enum_alu_oper_lsl, 16'hABCD, 16'h1234, 4'b1100, 16'hABCD, 4'b1100, 1'b1};
    vecs[7]  = '{enum_alu_oper_adc, 16'h0001, 16'h0001, 4'b1101, 16'h0003, 4'b1100, 1'b0};
    vecs[8]  = '{enum_alu_oper_xor, 16'h5555, 16'h5555, 4'b0101, 16'h0000, 4'b0111, 1'b0};
    vecs[9]  = '{enum_alu_oper_orr, 16'h0000, 16'h0000, 4'b0010, 16'h0000, 4'b0010, 1'b0};
    vecs[10] = '{enum_alu_oper_sbc, 16'h1000, 16'h0001, 4'b0001, 16'h0FFF, 4'b0001, 1'b0};
    vecs[11] = '{enum_alu_oper_ror, 16'h8001, 16'h0000, 4'b1010, 16'h8001, 4'b1010, 1'b1};

    repeat (3) @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset err", {31'b0, err}, 32'd0);
    check("reset out", {16'b0, out}, 32'd0);
    check("reset flags", {28'b0, proc_flags_out}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].f, r, fo, e, lat);
      check($sformatf("vec%0d out", i), {16'b0, r}, {16'b0, vecs[i].eo});
      check($sformatf("vec%0d flags", i), {28'b0, fo}, {28'b0, vecs[i].ef});
      check($sformatf("vec%0d err", i), {31'b0, e}, {31'b0, vecs[i].ee});
      check($sformatf("vec%0d latency", i), lat, vecs[i].ee ? 1 : 3);
    end

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op, f;
      logic [15:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      f  = 4'($urandom);
      if (i % 8 == 0) b = a;
      model(op, a, b, f, mo, mf, me);
      run_op(op, a, b, f, r, fo, e, lat);
      check($sformatf("rnd%0d op%0d out", i, op), {16'b0, r}, {16'b0, mo});
      check($sformatf("rnd%0d op%0d flags", i, op), {28'b0, fo}, {28'b0, mf});
      check($sformatf("rnd%0d op%0d err", i, op), {31'b0, e}, {31'b0, me});
      check($sformatf("rnd%0d op%0d latency", i, op), lat, me ? 1 : 3);
    end

    // Unsupported op followed by a supported one: err must clear.
    run_op(enum_alu_oper_lsr, 16'h0F0F, 16'h0001, 4'b0000, r, fo, e, lat);
    check("unsup err", {31'b0, e}, 32'd1);
    run_op(enum_alu_oper_add, 16'h0001, 16'h0002, 4'b0000, r, fo, e, lat);
    check("err cleared", {31'b0, e}, 32'd0);
    check("err cleared out", {16'b0, r}, 32'h0003);

    // Reset during RUN abandons the operation.
    @(negedge clk);
    oper = enum_alu_oper_add; a_in = 16'h1111; b_in = 16'h2222; proc_flags_in = 4'b0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("midrun busy", {31'b0, busy}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("post reset busy", {31'b0, busy}, 32'd0);
    check("post reset done", {31'b0, done}, 32'd0);
    check("post reset out", {16'b0, out}, 32'd0);
    check("post reset flags", {28'b0, proc_flags_out}, 32'd0);
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("post reset no done", dones, 0);

    // start held high through RUN and FIN: exactly one done.
    @(negedge clk);
    oper = enum_alu_oper_sub; a_in = 16'h0300; b_in = 16'h0101; proc_flags_in = 4'b0000; start = 1'b1;
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("held start done count", dones, 1);
    check("held start out", {16'b0, out}, 32'h01FF);
    check("held start flags", {28'b0, proc_flags_out}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
